// File: rtl/da_fir_pkg.sv
// Shared definitions for the distributed-arithmetic FIR core and its stream feeder.
package da_fir_pkg;

    localparam int OPSIZE_DEFAULT = 12;
    localparam int BAAT_DEFAULT   = 3;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT
    } feeder_state_t;

    // Core iterations per sample.
    function automatic int cyc(input int opsize, input int baat);
        return opsize / baat;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head output and an occupancy count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (level == (AW+1)'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            // Power-of-two depth lets the pointers wrap on their own.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // NOTE: storage has no reset; entries are only read after being written, so it can map to RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/da_fir_feeder.sv
// Stream front-end for the DA FIR core: buffers samples, launches one computation per sample,
// and returns each result on a back-pressured output stream.
module da_fir_feeder
    import da_fir_pkg::*;
#(
    parameter int OPSIZE  = OPSIZE_DEFAULT,
    parameter int BAAT    = BAAT_DEFAULT,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [OPSIZE-1:0]        s_data,
    output logic                     fir_start,
    output logic [OPSIZE-1:0]        fir_xin,
    input  logic                     fir_ready,
    input  logic [OPSIZE:0]          fir_yout,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [OPSIZE:0]          m_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic                     err
);

    localparam int CW = $clog2(TIMEOUT);

    if (OPSIZE % BAAT != 0) begin : g_bad_baat
        $error("OPSIZE must be a multiple of BAAT");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two, at least 2");
    end
    if (TIMEOUT <= cyc(OPSIZE, BAAT) + 2) begin : g_bad_timeout
        $error("TIMEOUT must exceed one core computation");
    end

    feeder_state_t     state;
    feeder_state_t     state_nxt;
    logic [CW-1:0]     wait_cnt;
    logic              launch;
    logic              capture;
    logic              timeout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [OPSIZE-1:0] fifo_head;

    sync_fifo #(
        .WIDTH (OPSIZE),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s_valid && s_ready),
        .push_data (s_data),
        .pop       (launch),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    assign s_ready   = !fifo_full;
    assign fir_start = (state == START);
    assign busy      = (state != IDLE);

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        capture   = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                // Launch only into an idle core so it is never restarted mid-computation.
                if (!fifo_empty && fir_ready) begin
                    launch    = 1'b1;
                    state_nxt = START;
                end
            end
            START: state_nxt = WAIT;
            WAIT: begin
                if (fir_ready) begin
                    // The core holds yout while idle, so a blocked output slot just waits here.
                    if (!m_valid || m_ready) begin
                        capture   = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fir_xin  <= '0;
            wait_cnt <= '0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (launch) fir_xin <= fifo_head;
            // Only cycles spent waiting on the core count toward the timeout.
            if (state != WAIT)   wait_cnt <= '0;
            else if (!fir_ready) wait_cnt <= wait_cnt + 1'b1;
            if (capture) begin
                m_valid <= 1'b1;
                m_data  <= fir_yout;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
            if (timeout) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_da_fir_feeder.sv
// Randomized bench for da_fir_feeder with a behavioural FIR core and a scoreboard model.
module tb_da_fir_feeder;

    localparam int OPSIZE  = 12;
    localparam int BAAT    = 3;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 64;
    localparam int CYC     = OPSIZE / BAAT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [11:0] s_data = '0;
    logic        fir_start;
    logic [11:0] fir_xin;
    logic        fir_ready;
    logic [12:0] fir_yout;
    logic        m_valid;
    logic        m_ready;
    logic [12:0] m_data;
    logic [3:0]  level;
    logic        busy;
    logic        err;

    logic m_ready_drv = 1'b1;
    logic rand_ready  = 1'b0;
    logic rnd_ready   = 1'b1;
    assign m_ready = rand_ready ? rnd_ready : m_ready_drv;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;
    always @(posedge clk) begin
        #1;
        rnd_ready = 1'($urandom_range(0, 1));
    end

    da_fir_feeder #(
        .OPSIZE  (OPSIZE),
        .BAAT    (BAAT),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .fir_start (fir_start),
        .fir_xin   (fir_xin),
        .fir_ready (fir_ready),
        .fir_yout  (fir_yout),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .level     (level),
        .busy      (busy),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    // Golden 4-tap FIR, result kept to the core's OPSIZE+1 output bits.
    function automatic logic [12:0] fir_eval(input int x0, input int x1, input int x2, input int x3);
        logic [31:0] s;
        s = 32'(3 * x0 - 5 * x1 + 7 * x2 + 2 * x3);
        return s[12:0];
    endfunction

    // Behavioural core: samples start while idle, busy for CYC cycles, then holds its result.
    logic        stall = 1'b0;
    logic        core_ready;
    logic [12:0] core_y;
    int          core_cnt;
    int          core_hist [4];
    assign fir_ready = core_ready;
    assign fir_yout  = core_y;

    always @(posedge clk) begin
        if (rst) begin
            core_ready <= 1'b1;
            core_y     <= '0;
            core_cnt   <= 0;
            foreach (core_hist[i]) core_hist[i] <= 0;
        end else if (core_ready) begin
            if (fir_start) begin
                core_ready   <= 1'b0;
                core_cnt     <= CYC;
                core_hist[0] <= int'($signed(fir_xin));
                core_hist[1] <= core_hist[0];
                core_hist[2] <= core_hist[1];
                core_hist[3] <= core_hist[2];
            end
        end else if (!stall) begin
            if (core_cnt == 1) begin
                core_ready <= 1'b1;
                core_y     <= fir_eval(core_hist[0], core_hist[1], core_hist[2], core_hist[3]);
            end else begin
                core_cnt <= core_cnt - 1;
            end
        end
    end

    // Scoreboard: expected results in push order, occupancy model, launch spacing.
    logic [12:0] exp_q [$];
    int          mh [4];
    int          model_level = 0;
    int          last_start  = -1;
    logic        burst_on    = 1'b0;
    logic        drop_mode   = 1'b0;
    logic        saw_full    = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            model_level = 0;
            exp_q.delete();
            foreach (mh[i]) mh[i] = 0;
        end else begin
            if (!burst_on) last_start = -1;
            if (fir_start) begin
                model_level--;
                check("start_needs_ready", 32'(fir_ready), 32'd1);
                if (burst_on && last_start >= 0) check("start_gap", 32'(cycle - last_start), 32'(CYC + 3));
                last_start = cycle;
            end
            check("level", 32'(level), 32'(model_level));
            check("s_ready", 32'(s_ready), 32'(model_level != DEPTH));
            if (model_level == DEPTH) saw_full = 1'b1;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) check("spurious_result", 32'(m_valid), 32'd0);
                else                   check("result", 32'(m_data), 32'(exp_q.pop_front()));
            end
            if (s_valid && s_ready) begin
                model_level++;
                mh[3] = mh[2];
                mh[2] = mh[1];
                mh[1] = mh[0];
                mh[0] = int'($signed(s_data));
                if (!drop_mode) exp_q.push_back(fir_eval(mh[0], mh[1], mh[2], mh[3]));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    // Called one time unit after a rising edge; returns one time unit after the accepting edge.
    task automatic push(input logic [11:0] d);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        @(negedge clk);
        while (!s_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) check("push_accept", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || busy || level != 0) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_s_ready"}, 32'(s_ready), 32'd1);
        check({tag, "_fir_start"}, 32'(fir_start), 32'd0);
        check({tag, "_fir_xin"}, 32'(fir_xin), 32'd0);
        check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        check({tag, "_m_data"}, 32'(m_data), 32'd0);
        check({tag, "_level"}, 32'(level), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();
        @(negedge clk);
        check_reset_values("reset");
        step(1);

        // Single impulse: result visible right after the seventh edge past acceptance.
        push(12'h7ff);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("single_m_valid_early", 32'(m_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("single_m_valid", 32'(m_valid), 32'd1);
        check("single_xin", 32'(fir_xin), 32'h7ff);
        check("single_data", 32'(m_data), 32'(fir_eval(2047, 0, 0, 0)));
        step(1);
        wait_drain("single");

        // Burst of 10 back-to-back samples with a free output.
        step(2);
        burst_on = 1'b1;
        for (int i = 0; i < 10; i++) push(12'($urandom));
        wait_drain("burst");
        burst_on = 1'b0;
        check("burst_saw_full", 32'(saw_full), 32'd1);
        check("burst_err", 32'(err), 32'd0);

        // Back-pressure: three computations with the output blocked.
        m_ready_drv = 1'b0;
        for (int i = 0; i < 3; i++) push(12'($urandom));
        step(40);
        @(negedge clk);
        check("bp_busy", 32'(busy), 32'd1);
        check("bp_m_valid", 32'(m_valid), 32'd1);
        check("bp_level", 32'(level), 32'd1);
        check("bp_pending", 32'(exp_q.size()), 32'd3);
        check("bp_head_data", 32'(m_data), 32'(exp_q[0]));
        step(1);
        m_ready_drv = 1'b1;
        wait_drain("bp");

        // Timeout: the core never finishes, the sample is dropped.
        stall     = 1'b1;
        drop_mode = 1'b1;
        push(12'($urandom));
        drop_mode = 1'b0;
        repeat (2) @(posedge clk);
        repeat (TIMEOUT - 1) @(posedge clk);
        @(negedge clk);
        check("to_err_before", 32'(err), 32'd0);
        check("to_busy_before", 32'(busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("to_err", 32'(err), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        check("to_m_valid", 32'(m_valid), 32'd0);
        step(1);
        stall = 1'b0;
        step(10);
        check("to_err_sticky", 32'(err), 32'd1);
        check("to_no_result", 32'(m_valid), 32'd0);
        push(12'($urandom));
        wait_drain("after_to");
        check("to_err_kept", 32'(err), 32'd1);
        do_reset();
        @(negedge clk);
        check("to_err_cleared", 32'(err), 32'd0);
        step(1);

        // Reset while waiting on the core.
        push(12'($urandom));
        repeat (3) @(posedge clk);
        #1;
        check("rw_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("rw");
        step(15);
        check("rw_no_m_valid", 32'(m_valid), 32'd0);
        check("rw_idle", 32'(busy), 32'd0);

        // FIFO wrap: 20 back-to-back samples with random output back-pressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 20; i++) push(12'($urandom));
        wait_drain("wrap");
        rand_ready = 1'b0;
        check("final_err", 32'(err), 32'd0);

        step(5);
        check("leftover", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
